// File: rtl/ld_st_control_sequencer_pkg.sv
// ============================================================================
//  Module      : ld_st_control_sequencer_pkg
//  Description : Datapath strobe bit map, sequencer state encoding and
//                step constants shared by the load/store sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ld_st_control_sequencer_pkg;

  localparam int CTRL_W = 26;

  localparam int CTL_PCOUT     = 0;
  localparam int CTL_ZLOWOUT   = 1;
  localparam int CTL_ZHIOUT    = 2;
  localparam int CTL_MDROUT    = 3;
  localparam int CTL_HIOUT     = 4;
  localparam int CTL_LOOUT     = 5;
  localparam int CTL_COUT      = 6;
  localparam int CTL_INPORTOUT = 7;
  localparam int CTL_MARIN     = 8;
  localparam int CTL_ZIN       = 9;
  localparam int CTL_PCIN      = 10;
  localparam int CTL_MDRIN     = 11;
  localparam int CTL_IRIN      = 12;
  localparam int CTL_YIN       = 13;
  localparam int CTL_HIIN      = 14;
  localparam int CTL_LOIN      = 15;
  localparam int CTL_INCPC     = 16;
  localparam int CTL_READ      = 17;
  localparam int CTL_WRITE     = 18;
  localparam int CTL_GRA       = 19;
  localparam int CTL_GRB       = 20;
  localparam int CTL_GRC       = 21;
  localparam int CTL_RIN       = 22;
  localparam int CTL_ROUT      = 23;
  localparam int CTL_BAOUT     = 24;
  localparam int CTL_CONIN     = 25;

  localparam logic [3:0] STEP_NONE = 4'hF;

  // T-states encode their own step number so step can be driven straight from state.
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_IDLE  = 4'd8,
    S_FAULT = 4'd9
  } state_e;

  function automatic logic [CTRL_W-1:0] ctl_bit(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ld_st_control_sequencer_mem_wait_timer.sv
// ============================================================================
//  Module      : ld_st_control_sequencer_mem_wait_timer
//  Description : Counts stalled memory cycles within one step and flags a
//                timeout on the MEM_TO-th stalled cycle (MEM_TO=0 disables).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_st_control_sequencer_mem_wait_timer #(
  parameter int MEM_TO = 15
) (
  input  logic Clock,
  input  logic Clear,
  input  logic step_change_i,
  input  logic count_en_i,
  output logic timeout_o
);

  localparam int CNT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step_change_i) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (MEM_TO != 0) && count_en_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/ld_st_control_sequencer.sv
// ============================================================================
//  Module      : ld_st_control_sequencer
//  Description : Load/store control-step FSM driving Datapath strobes, with
//                memory wait, timeout fault and instr_done. Optional
//                single-step mode under macro SINGLE_STEP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_st_control_sequencer
  import ld_st_control_sequencer_pkg::*;
#(
  parameter int OPC_W  = 5,
  parameter int OP_LD  = 0,
  parameter int OP_LDI = 1,
  parameter int OP_ST  = 2,
  parameter int MEM_TO = 15
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              run,
  input  logic [OPC_W-1:0]  ir_opcode,
  input  logic              mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic              step_req,
`endif
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        step,
  output logic              instr_done,
  output logic              fault
);

  localparam logic [OPC_W-1:0] C_LD  = OPC_W'(OP_LD);
  localparam logic [OPC_W-1:0] C_LDI = OPC_W'(OP_LDI);
  localparam logic [OPC_W-1:0] C_ST  = OPC_W'(OP_ST);

  // Register-write strobes that must fire only once per step, however long it lasts.
  localparam logic [CTRL_W-1:0] PULSE_MASK =
      ctl_bit(CTL_ZIN) | ctl_bit(CTL_INCPC) | ctl_bit(CTL_PCIN) | ctl_bit(CTL_RIN) |
      ctl_bit(CTL_MARIN) | ctl_bit(CTL_IRIN) | ctl_bit(CTL_YIN);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q;
  logic             first_q;
  logic             go, advance, final_step, mem_pend, timeout;
  logic             is_ld, is_ldi, is_st, legal_op;

`ifdef SINGLE_STEP_EN
  assign go = step_req;
`else
  assign go = 1'b1;
`endif

  assign is_ld    = (op_q == C_LD);
  assign is_ldi   = (op_q == C_LDI);
  assign is_st    = (op_q == C_ST);
  assign legal_op = (ir_opcode == C_LD) || (ir_opcode == C_LDI) || (ir_opcode == C_ST);
  assign mem_pend = (state_q == S_T1) || ((state_q == S_T6) && is_ld) ||
                    ((state_q == S_T7) && is_st);
  assign advance  = (state_d != state_q);

  ld_st_control_sequencer_mem_wait_timer #(.MEM_TO(MEM_TO)) u_wait_timer (
    .Clock         (Clock),
    .Clear         (Clear),
    .step_change_i (advance),
    .count_en_i    (mem_pend && !mem_ready && go),
    .timeout_o     (timeout)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= advance;
      if ((state_q == S_T2) && advance) begin
        op_q <= ir_opcode;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    final_step = 1'b0;
    case (state_q)
      S_IDLE: if (run && go) state_d = S_T0;
      S_T0:   if (go) state_d = S_T1;
      S_T1:   if (go && mem_ready) state_d = S_T2;
      S_T2:   if (go) state_d = legal_op ? S_T3 : S_FAULT;
      S_T3:   if (go) state_d = S_T4;
      S_T4:   if (go) state_d = S_T5;
      S_T5: begin
        if (is_ldi) begin
          final_step = 1'b1;
          if (go) state_d = run ? S_T0 : S_IDLE;
        end else if (go) begin
          state_d = S_T6;
        end
      end
      S_T6:   if (go && (is_st || mem_ready)) state_d = S_T7;
      S_T7: begin
        final_step = 1'b1;
        if (go && (is_ld || mem_ready)) state_d = run ? S_T0 : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (timeout) state_d = S_FAULT;
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_T0: ctrl = ctl_bit(CTL_PCOUT) | ctl_bit(CTL_MARIN) | ctl_bit(CTL_INCPC) | ctl_bit(CTL_ZIN);
      S_T1: begin
        ctrl = ctl_bit(CTL_READ) | ctl_bit(CTL_MDRIN);
        if (first_q) ctrl = ctrl | ctl_bit(CTL_ZLOWOUT) | ctl_bit(CTL_PCIN);
      end
      S_T2: ctrl = ctl_bit(CTL_MDROUT) | ctl_bit(CTL_IRIN);
      S_T3: ctrl = ctl_bit(CTL_GRB) | ctl_bit(CTL_BAOUT) | ctl_bit(CTL_YIN);
      S_T4: ctrl = ctl_bit(CTL_COUT) | ctl_bit(CTL_ZIN);
      S_T5: ctrl = is_ldi ? (ctl_bit(CTL_ZLOWOUT) | ctl_bit(CTL_GRA) | ctl_bit(CTL_RIN))
                          : (ctl_bit(CTL_ZLOWOUT) | ctl_bit(CTL_MARIN));
      S_T6: ctrl = is_ld ? (ctl_bit(CTL_READ) | ctl_bit(CTL_MDRIN))
                         : (ctl_bit(CTL_GRA) | ctl_bit(CTL_ROUT) | ctl_bit(CTL_MDRIN));
      S_T7: ctrl = is_ld ? (ctl_bit(CTL_MDROUT) | ctl_bit(CTL_GRA) | ctl_bit(CTL_RIN))
                         : ctl_bit(CTL_WRITE);
      default: ctrl = '0;
    endcase
    if (!first_q) ctrl = ctrl & ~PULSE_MASK;
    step       = state_q[3] ? STEP_NONE : state_q;
    fault      = (state_q == S_FAULT);
    instr_done = final_step && advance;
  end

endmodule

`default_nettype wire

// File: tb/tb_ld_st_control_sequencer.sv
// ============================================================================
//  Module      : tb_ld_st_control_sequencer
//  Description : Directed self-checking bench for ld_st_control_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ld_st_control_sequencer;
  import ld_st_control_sequencer_pkg::*;

  localparam logic [CTRL_W-1:0] E_T0   = ctl_bit(CTL_PCOUT) | ctl_bit(CTL_MARIN) | ctl_bit(CTL_INCPC) | ctl_bit(CTL_ZIN);
  localparam logic [CTRL_W-1:0] E_T1   = ctl_bit(CTL_READ) | ctl_bit(CTL_MDRIN) | ctl_bit(CTL_ZLOWOUT) | ctl_bit(CTL_PCIN);
  localparam logic [CTRL_W-1:0] E_T1W  = ctl_bit(CTL_READ) | ctl_bit(CTL_MDRIN);
  localparam logic [CTRL_W-1:0] E_T2   = ctl_bit(CTL_MDROUT) | ctl_bit(CTL_IRIN);
  localparam logic [CTRL_W-1:0] E_T3   = ctl_bit(CTL_GRB) | ctl_bit(CTL_BAOUT) | ctl_bit(CTL_YIN);
  localparam logic [CTRL_W-1:0] E_T4   = ctl_bit(CTL_COUT) | ctl_bit(CTL_ZIN);
  localparam logic [CTRL_W-1:0] E_T5   = ctl_bit(CTL_ZLOWOUT) | ctl_bit(CTL_MARIN);
  localparam logic [CTRL_W-1:0] E_T5I  = ctl_bit(CTL_ZLOWOUT) | ctl_bit(CTL_GRA) | ctl_bit(CTL_RIN);
  localparam logic [CTRL_W-1:0] E_T6L  = ctl_bit(CTL_READ) | ctl_bit(CTL_MDRIN);
  localparam logic [CTRL_W-1:0] E_T6S  = ctl_bit(CTL_GRA) | ctl_bit(CTL_ROUT) | ctl_bit(CTL_MDRIN);
  localparam logic [CTRL_W-1:0] E_T7L  = ctl_bit(CTL_MDROUT) | ctl_bit(CTL_GRA) | ctl_bit(CTL_RIN);
  localparam logic [CTRL_W-1:0] E_T7S  = ctl_bit(CTL_WRITE);

  logic              Clock = 1'b0;
  logic              Clear = 1'b1;
  logic              run = 1'b0;
  logic [4:0]        ir_opcode = 5'd0;
  logic              mem_ready = 1'b1;
  logic              step_req = 1'b1;
  logic [CTRL_W-1:0] ctrl;
  logic [3:0]        step;
  logic              instr_done;
  logic              fault;

  int n_chk = 0;
  int n_fail = 0;
  logic [CTRL_W-1:0] exp_ld [8];

  always #5 Clock = ~Clock;

  ld_st_control_sequencer #(.OPC_W(5), .OP_LD(0), .OP_LDI(1), .OP_ST(2), .MEM_TO(15)) dut (
    .Clock      (Clock),
    .Clear      (Clear),
    .run        (run),
    .ir_opcode  (ir_opcode),
    .mem_ready  (mem_ready),
`ifdef SINGLE_STEP_EN
    .step_req   (step_req),
`endif
    .ctrl       (ctrl),
    .step       (step),
    .instr_done (instr_done),
    .fault      (fault)
  );

  // Inputs change on negedge; outputs are sampled 1 time unit later.
  task automatic do_clear();
    @(negedge Clock);
    Clear = 1'b1; run = 1'b0; mem_ready = 1'b1; step_req = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic test_reset();
    do_clear();
    #1;
    n_chk++; if (ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
    n_chk++; if (step !== 4'hF) begin n_fail++; $display("FAIL reset_step: got %h expected f", step); end
    n_chk++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", instr_done); end
    n_chk++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
  endtask

  task automatic test_ld();
    ir_opcode = 5'd0; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (i == 7) run = 1'b0;
      #1;
      n_chk++; if (step !== 4'(i)) begin n_fail++; $display("FAIL ld_step%0d: got %h expected %h", i, step, 4'(i)); end
      n_chk++; if (ctrl !== exp_ld[i]) begin n_fail++; $display("FAIL ld_ctrl%0d: got %h expected %h", i, ctrl, exp_ld[i]); end
      n_chk++; if (instr_done !== (i == 7)) begin n_fail++; $display("FAIL ld_done%0d: got %b expected %b", i, instr_done, (i == 7)); end
    end
    @(negedge Clock); #1;
    n_chk++; if (step !== 4'hF) begin n_fail++; $display("FAIL ld_idle_step: got %h expected f", step); end
    n_chk++; if (ctrl !== '0) begin n_fail++; $display("FAIL ld_idle_ctrl: got %h expected 0", ctrl); end
  endtask

  task automatic test_ldi();
    ir_opcode = 5'd1; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock); #1;
      n_chk++; if (step !== 4'(i)) begin n_fail++; $display("FAIL ldi_step%0d: got %h expected %h", i, step, 4'(i)); end
      n_chk++; if (instr_done !== (i == 5)) begin n_fail++; $display("FAIL ldi_done%0d: got %b expected %b", i, instr_done, (i == 5)); end
    end
    n_chk++; if (ctrl !== E_T5I) begin n_fail++; $display("FAIL ldi_t5_ctrl: got %h expected %h", ctrl, E_T5I); end
    @(negedge Clock); #1;
    n_chk++; if (step !== 4'd0) begin n_fail++; $display("FAIL ldi_restart_step: got %h expected 0", step); end
    n_chk++; if (ctrl !== E_T0) begin n_fail++; $display("FAIL ldi_restart_ctrl: got %h expected %h", ctrl, E_T0); end
    do_clear();
  endtask

  task automatic test_st_wait();
    ir_opcode = 5'd2; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clock); #1;
      n_chk++; if (step !== 4'(i)) begin n_fail++; $display("FAIL st_step%0d: got %h expected %h", i, step, 4'(i)); end
    end
    n_chk++; if (ctrl !== E_T6S) begin n_fail++; $display("FAIL st_t6_ctrl: got %h expected %h", ctrl, E_T6S); end
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      mem_ready = (k == 3); run = (k != 3);
      #1;
      n_chk++; if (step !== 4'd7) begin n_fail++; $display("FAIL st_t7_step%0d: got %h expected 7", k, step); end
      n_chk++; if (ctrl !== E_T7S) begin n_fail++; $display("FAIL st_t7_ctrl%0d: got %h expected %h", k, ctrl, E_T7S); end
      n_chk++; if (instr_done !== (k == 3)) begin n_fail++; $display("FAIL st_t7_done%0d: got %b expected %b", k, instr_done, (k == 3)); end
    end
    @(negedge Clock); mem_ready = 1'b1; #1;
    n_chk++; if (step !== 4'hF) begin n_fail++; $display("FAIL st_idle_step: got %h expected f", step); end
  endtask

  task automatic test_t1_wait();
    ir_opcode = 5'd0; mem_ready = 1'b1; run = 1'b1;
    @(negedge Clock); #1;
    n_chk++; if (step !== 4'd0) begin n_fail++; $display("FAIL t1w_t0_step: got %h expected 0", step); end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      mem_ready = (k == 2);
      #1;
      n_chk++; if (step !== 4'd1) begin n_fail++; $display("FAIL t1w_step%0d: got %h expected 1", k, step); end
      n_chk++; if (ctrl !== ((k == 0) ? E_T1 : E_T1W)) begin n_fail++; $display("FAIL t1w_ctrl%0d: got %h expected %h", k, ctrl, (k == 0) ? E_T1 : E_T1W); end
    end
    @(negedge Clock); #1;
    n_chk++; if (step !== 4'd2) begin n_fail++; $display("FAIL t1w_t2_step: got %h expected 2", step); end
    do_clear();
  endtask

  task automatic test_illegal();
    ir_opcode = 5'h1F; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge Clock);
    #1;
    n_chk++; if (step !== 4'd2) begin n_fail++; $display("FAIL ill_t2_step: got %h expected 2", step); end
    @(negedge Clock); #1;
    n_chk++; if (fault !== 1'b1) begin n_fail++; $display("FAIL ill_fault: got %b expected 1", fault); end
    n_chk++; if (ctrl !== '0) begin n_fail++; $display("FAIL ill_ctrl: got %h expected 0", ctrl); end
    n_chk++; if (step !== 4'hF) begin n_fail++; $display("FAIL ill_step: got %h expected f", step); end
    @(negedge Clock); #1;
    n_chk++; if (fault !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: got %b expected 1", fault); end
    do_clear(); #1;
    n_chk++; if (fault !== 1'b0) begin n_fail++; $display("FAIL ill_clear_fault: got %b expected 0", fault); end
  endtask

  task automatic test_timeout();
    ir_opcode = 5'd0; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge Clock);
    for (int k = 0; k < 15; k++) begin
      @(negedge Clock);
      mem_ready = 1'b0;
      #1;
      n_chk++; if (step !== 4'd6 || fault !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got step %h fault %b expected step 6 fault 0", k, step, fault); end
    end
    @(negedge Clock); #1;
    n_chk++; if (fault !== 1'b1) begin n_fail++; $display("FAIL to_fault: got %b expected 1", fault); end
    n_chk++; if (step !== 4'hF) begin n_fail++; $display("FAIL to_step: got %h expected f", step); end
    do_clear(); #1;
    n_chk++; if (fault !== 1'b0 || step !== 4'hF) begin n_fail++; $display("FAIL to_clear: got fault %b step %h expected 0 f", fault, step); end
  endtask

  task automatic test_clear_mid();
    ir_opcode = 5'd0; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge Clock);
    #1;
    n_chk++; if (step !== 4'd4 || ctrl !== E_T4) begin n_fail++; $display("FAIL clr_t4: got step %h ctrl %h expected 4 %h", step, ctrl, E_T4); end
    Clear = 1'b1;
    @(negedge Clock); #1;
    n_chk++; if (ctrl !== '0) begin n_fail++; $display("FAIL clr_ctrl: got %h expected 0", ctrl); end
    n_chk++; if (step !== 4'hF) begin n_fail++; $display("FAIL clr_step: got %h expected f", step); end
    Clear = 1'b0; run = 1'b0;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    do_clear();
    ir_opcode = 5'd0; mem_ready = 1'b1; run = 1'b1; step_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      step_req = (k == 2);
      #1;
      n_chk++; if (step !== 4'd0) begin n_fail++; $display("FAIL ss_t0_step%0d: got %h expected 0", k, step); end
      n_chk++; if (ctrl[CTL_ZIN] !== (k == 0)) begin n_fail++; $display("FAIL ss_zin%0d: got %b expected %b", k, ctrl[CTL_ZIN], (k == 0)); end
      n_chk++; if (ctrl[CTL_PCOUT] !== 1'b1) begin n_fail++; $display("FAIL ss_pcout%0d: got %b expected 1", k, ctrl[CTL_PCOUT]); end
    end
    @(negedge Clock); step_req = 1'b0; #1;
    n_chk++; if (step !== 4'd1 || ctrl !== E_T1) begin n_fail++; $display("FAIL ss_t1: got step %h ctrl %h expected 1 %h", step, ctrl, E_T1); end
    do_clear();
  endtask
`endif

  initial begin
    exp_ld[0] = E_T0; exp_ld[1] = E_T1; exp_ld[2] = E_T2; exp_ld[3] = E_T3;
    exp_ld[4] = E_T4; exp_ld[5] = E_T5; exp_ld[6] = E_T6L; exp_ld[7] = E_T7L;
    test_reset();
    test_ld();
    test_ldi();
    test_st_wait();
    test_t1_wait();
    test_illegal();
    test_timeout();
    test_clear_mid();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
